// File: rtl/decoder_3to8_seq_pkg.sv
// Shared types and width relations for the one-hot encoder/decoder pair.
package decoder_3to8_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam int IDX_W_DEF       = 3;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int CNT_W_DEF       = 8;

  // Output word width of a decoder (input width of the matching encoder).
  function automatic int dec_out_w(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage

// File: rtl/decoder_3to8_seq_onehot_dec.sv
// Combinational binary index to one-hot decoder.
module onehot_dec
  import decoder_3to8_seq_pkg::*;
#(
  parameter  int IDX_W = IDX_W_DEF,
  localparam int OUT_W = dec_out_w(IDX_W)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequential decoder: holds each accepted index on y as a one-hot word for HOLD_CYCLES
// enabled clocks, with a one-entry buffer for gapless back-to-back words.
module decoder_3to8_seq
  import decoder_3to8_seq_pkg::*;
#(
  parameter  int IDX_W       = IDX_W_DEF,
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter  int CNT_W       = CNT_W_DEF,
  localparam int OUT_W       = dec_out_w(IDX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
  logic             done_q, done_d;

  logic [OUT_W-1:0] in_word;
  logic [OUT_W-1:0] buf_word;
  logic             accept;

  onehot_dec #(.IDX_W(IDX_W)) u_dec_in  (.idx(in_idx),    .onehot(in_word));
  onehot_dec #(.IDX_W(IDX_W)) u_dec_buf (.idx(buf_idx_q), .onehot(buf_word));

  assign in_ready = enable & ~buf_valid_q;
  assign accept   = in_valid & in_ready;
  assign y        = enable ? word_q : '0;
  assign y_valid  = enable & (state_q == DRIVE);
  assign done     = enable & done_q;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    // A pending done pulse stays frozen while disabled so it is never lost.
    done_d      = enable ? 1'b0 : done_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = DRIVE;
            word_d  = in_word;
            cnt_d   = RELOAD;
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (accept) begin
              buf_valid_d = 1'b1;
              buf_idx_d   = in_idx;
            end
          end else begin
            done_d = 1'b1;
            if (buf_valid_q) begin
              word_d      = buf_word;
              cnt_d       = RELOAD;
              buf_valid_d = 1'b0;
            end else if (accept) begin
              word_d = in_word;
              cnt_d  = RELOAD;
            end else begin
              state_d = IDLE;
              word_d  = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      done_q      <= done_d;
    end
  end

endmodule
